// File: rtl/dmem_responder.sv
// Memory-side responder for the data load/store port: one request at a time,
// programmable wait states, byte/half/word access on a word array, valid/ready response.
//
// state  | meaning
// IDLE   | ready for a request; captures it on handshake
// WAIT   | wait-state down-counter running, ends at terminal count 0
// ACCESS | validate, read or write the array, register the response
// RESP   | response presented until the requester takes it
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [CNT_W-1:0]  waitCnt;
    logic              capWrite;
    logic [31:0]       capAddr;
    logic [2:0]        capFunct3;
    logic [31:0]       capWdata;

    logic              loadReq;
    logic              doAccess;
    logic              respDone;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       memWord;
    logic [1:0]        sizeCode;
    logic              funct3Ok;
    logic              alignOk;
    logic              inRange;
    logic              accessOk;
    logic [3:0]        byteEn;
    logic [31:0]       wdataLanes;
    logic [7:0]        byteSel;
    logic [15:0]       halfSel;
    logic [31:0]       loadData;
    logic              memWrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        loadReq    = 1'b0;
        doAccess   = 1'b0;
        respDone   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    loadReq   = 1'b1;
                    nextState = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (waitCnt == '0) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                doAccess  = 1'b1;
                nextState = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    respDone  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt    <= '0;
            capWrite   <= 1'b0;
            capAddr    <= '0;
            capFunct3  <= '0;
            capWdata   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (loadReq) begin
                capWrite  <= req_write;
                capAddr   <= req_addr;
                capFunct3 <= req_funct3;
                capWdata  <= req_wdata;
                waitCnt   <= CNT_LOAD;
            end else if (state == WAIT && waitCnt != '0) begin
                waitCnt <= waitCnt - 1'b1;
            end

            if (doAccess) begin
                resp_rdata <= (accessOk && !capWrite) ? loadData : '0;
                resp_err   <= !accessOk;
            end else if (respDone) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

    // funct3[1:0] encodes the access size for every legal load/store opcode
    assign sizeCode = capFunct3[1:0];
    assign wordIdx  = capAddr[ADDR_W+1:2];
    assign memWord  = mem[wordIdx];
    assign inRange  = {2'b00, capAddr[31:2]} < 32'(DEPTH_WORDS);
    assign accessOk = funct3Ok && alignOk && inRange;
    assign memWrite = doAccess && capWrite && accessOk;

    always_comb begin
        funct3Ok = 1'b0;
        if (capWrite) begin
            funct3Ok = (capFunct3 == 3'd0) || (capFunct3 == 3'd1) || (capFunct3 == 3'd2);
        end else begin
            funct3Ok = (capFunct3 == 3'd0) || (capFunct3 == 3'd1) || (capFunct3 == 3'd2) ||
                       (capFunct3 == 3'd4) || (capFunct3 == 3'd5);
        end
    end

    always_comb begin
        alignOk    = 1'b1;
        byteEn     = 4'b1111;
        wdataLanes = capWdata;
        case (sizeCode)
            2'd0: begin
                byteEn     = 4'b0001 << capAddr[1:0];
                wdataLanes = {4{capWdata[7:0]}};
            end
            2'd1: begin
                alignOk    = !capAddr[0];
                byteEn     = capAddr[1] ? 4'b1100 : 4'b0011;
                wdataLanes = {2{capWdata[15:0]}};
            end
            default: begin
                alignOk = (capAddr[1:0] == 2'b00);
            end
        endcase
    end

    always_comb begin
        byteSel  = memWord[{capAddr[1:0], 3'b000} +: 8];
        halfSel  = capAddr[1] ? memWord[31:16] : memWord[15:0];
        loadData = '0;
        case (capFunct3)
            3'd0:    loadData = {{24{byteSel[7]}}, byteSel};
            3'd1:    loadData = {{16{halfSel[15]}}, halfSel};
            3'd2:    loadData = memWord;
            3'd4:    loadData = {24'h000000, byteSel};
            3'd5:    loadData = {16'h0000, halfSel};
            default: loadData = '0;
        endcase
    end

    // Array has no reset; a store only lands on the edge that leaves ACCESS
    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[wordIdx][8*b +: 8] <= wdataLanes[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states (index 0) and one with none
// (index 1), directed steps plus random traffic checked against a byte-level memory model.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]       reqValid, reqReady, reqWrite, respValid, respReady, respErr;
    logic [1:0][31:0] reqAddr, reqWdata, respRdata;
    logic [1:0][2:0]  reqFunct3;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acceptCyc = 0;
    bit [31:0] refMem [longint];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite[0]),
        .req_addr(reqAddr[0]), .req_funct3(reqFunct3[0]), .req_wdata(reqWdata[0]),
        .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite[1]),
        .req_addr(reqAddr[1]), .req_funct3(reqFunct3[1]), .req_wdata(reqWdata[1]),
        .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1])
    );

    function automatic int waitOf(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    // Reference: memory as bytes-in-words, access size from funct3, extension by plain masking
    function automatic void model(input int s, input bit wr, input bit [31:0] a, input bit [2:0] f3,
                                  input bit [31:0] wd, output bit [31:0] rd, output bit er);
        int nBytes;
        bit legal;
        longint key;
        bit [31:0] w;
        rd = 32'h0;
        er = 1'b0;
        key = longint'(s) * 64'd4294967296 + longint'(a / 4);
        nBytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal || (a % nBytes) != 0 || (a / 4) >= DEPTH) begin
            er = 1'b1;
            return;
        end
        w = refMem.exists(key) ? refMem[key] : 32'h0;
        if (wr) begin
            for (int i = 0; i < nBytes; i++) w[8*(a%4+i) +: 8] = wd[8*i +: 8];
            refMem[key] = w;
        end else begin
            for (int i = 0; i < nBytes; i++) rd[8*i +: 8] = w[8*(a%4+i) +: 8];
            if (f3 == 3'd0 && rd[7])  rd[31:8]  = '1;
            if (f3 == 3'd1 && rd[15]) rd[31:16] = '1;
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge
    task automatic sendReq(input int s, input bit wr, input bit [31:0] a, input bit [2:0] f3, input bit [31:0] wd);
        int n = 0;
        reqValid[s] = 1'b1; reqWrite[s] = wr; reqAddr[s] = a; reqFunct3[s] = f3; reqWdata[s] = wd;
        while (!reqReady[s] && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check("accept_wait", reqReady[s], 1'b1);
        @(posedge clk); @(negedge clk);
        reqValid[s] = 1'b0;
        acceptCyc = cyc;
    endtask

    task automatic getResp(input int s, input int hold, input bit [31:0] expRd, input bit expErr, input string tag);
        int n = 0;
        respReady[s] = (hold == 0);
        while (!respValid[s] && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check({tag, "_lat"}, n + 1, waitOf(s) + 2);
        check({tag, "_rdata"}, respRdata[s], expRd);
        check({tag, "_err"}, respErr[s], expErr);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check({tag, "_hold_valid"}, respValid[s], 1'b1);
            check({tag, "_hold_rdata"}, respRdata[s], expRd);
            check({tag, "_hold_err"}, respErr[s], expErr);
            check({tag, "_hold_reqready"}, reqReady[s], 1'b0);
        end
        respReady[s] = 1'b1;
        @(posedge clk); @(negedge clk);
        check({tag, "_done_valid"}, respValid[s], 1'b0);
        check({tag, "_done_reqready"}, reqReady[s], 1'b1);
        check({tag, "_done_rdata"}, respRdata[s], 32'h0);
        check({tag, "_done_err"}, respErr[s], 1'b0);
    endtask

    task automatic op(input int s, input bit wr, input bit [31:0] a, input bit [2:0] f3,
                      input bit [31:0] wd, input int hold, input string tag);
        bit [31:0] rd;
        bit er;
        model(s, wr, a, f3, wd, rd, er);
        sendReq(s, wr, a, f3, wd);
        getResp(s, hold, rd, er, tag);
    endtask

    // Directed step: model keeps the reference memory current, DUT is held to literal values
    task automatic opK(input int s, input bit wr, input bit [31:0] a, input bit [2:0] f3,
                       input bit [31:0] wd, input bit [31:0] expRd, input bit expErr, input string tag);
        bit [31:0] rd;
        bit er;
        model(s, wr, a, f3, wd, rd, er);
        sendReq(s, wr, a, f3, wd);
        getResp(s, 0, expRd, expErr, tag);
    endtask

    task automatic resetDuringWait(input int s);
        opK(s, 1, 32'h30, 3'd2, 32'h11111111, 32'h0, 1'b0, "rst_pre_sw");
        sendReq(s, 1, 32'h30, 3'd2, 32'h22222222);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_reqready", reqReady[s], 1'b1);
        check("rst_mid_valid", respValid[s], 1'b0);
        check("rst_mid_rdata", respRdata[s], 32'h0);
        check("rst_mid_err", respErr[s], 1'b0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        opK(s, 0, 32'h30, 3'd2, 32'h0, 32'h11111111, 1'b0, "rst_post_lw");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int n;
        rst = 1'b1;
        reqValid = '0; reqWrite = '0; reqAddr = '0; reqFunct3 = '0; reqWdata = '0;
        respReady = '1;
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_reqready", reqReady[s], 1'b1);
            check("reset_valid", respValid[s], 1'b0);
            check("reset_rdata", respRdata[s], 32'h0);
            check("reset_err", respErr[s], 1'b0);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        opK(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
        opK(0, 0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
        opK(0, 1, 32'h13, 3'd0, 32'h00000080, 32'h0, 1'b0, "sb_13");
        opK(0, 0, 32'h13, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0, "lb_13");
        opK(0, 0, 32'h13, 3'd4, 32'h0, 32'h00000080, 1'b0, "lbu_13");
        opK(0, 0, 32'h10, 3'd2, 32'h0, 32'h80ADBEEF, 1'b0, "lw_10_lane");
        opK(0, 1, 32'h20, 3'd2, 32'hCAFE5678, 32'h0, 1'b0, "sw_20");
        opK(0, 1, 32'h22, 3'd1, 32'h12348001, 32'h0, 1'b0, "sh_22");
        opK(0, 0, 32'h22, 3'd1, 32'h0, 32'hFFFF8001, 1'b0, "lh_22");
        opK(0, 0, 32'h22, 3'd5, 32'h0, 32'h00008001, 1'b0, "lhu_22");
        opK(0, 0, 32'h20, 3'd2, 32'h0, 32'h80015678, 1'b0, "lw_20");

        opK(0, 1, 32'h24, 3'd2, 32'h01020304, 32'h0, 1'b0, "sw_24");
        opK(0, 0, 32'h11, 3'd2, 32'h0, 32'h0, 1'b1, "err_lw_mis");
        opK(0, 1, 32'h21, 3'd1, 32'h0000FFFF, 32'h0, 1'b1, "err_sh_mis");
        opK(0, 0, 32'(4 * DEPTH), 3'd2, 32'h0, 32'h0, 1'b1, "err_range");
        opK(0, 1, 32'h24, 3'd4, 32'hAAAAAAAA, 32'h0, 1'b1, "err_st_f3");
        opK(0, 0, 32'h10, 3'd2, 32'h0, 32'h80ADBEEF, 1'b0, "err_keep_10");
        opK(0, 0, 32'h20, 3'd2, 32'h0, 32'h80015678, 1'b0, "err_keep_20");
        opK(0, 0, 32'h24, 3'd2, 32'h0, 32'h01020304, 1'b0, "err_keep_24");

        // Backpressure with a second request held pending while busy
        sendReq(0, 0, 32'h10, 3'd2, 32'h0);
        reqValid[0] = 1'b1; reqWrite[0] = 1'b0; reqAddr[0] = 32'h20; reqFunct3[0] = 3'd2;
        getResp(0, 5, 32'h80ADBEEF, 1'b0, "bp");
        opK(0, 0, 32'h20, 3'd2, 32'h0, 32'h80015678, 1'b0, "bp_next");

        // Throughput with the requester always ready
        opK(0, 0, 32'h10, 3'd2, 32'h0, 32'h80ADBEEF, 1'b0, "tp_a");
        a1 = acceptCyc;
        opK(0, 0, 32'h24, 3'd2, 32'h0, 32'h01020304, 1'b0, "tp_b");
        check("tp_period_w2", acceptCyc - a1, 5);

        // Reset while a response is waiting clears the held data immediately
        respReady[0] = 1'b0;
        sendReq(0, 0, 32'h10, 3'd2, 32'h0);
        n = 0;
        while (!respValid[0] && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check("rresp_rdata", respRdata[0], 32'h80ADBEEF);
        #1 rst = 1'b1;
        #1;
        check("rresp_valid", respValid[0], 1'b0);
        check("rresp_rdata_clr", respRdata[0], 32'h0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        respReady[0] = 1'b1;

        resetDuringWait(0);

        opK(1, 1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, "w0_sw_10");
        opK(1, 0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, "w0_lw_10");
        a1 = acceptCyc;
        opK(1, 0, 32'h12, 3'd1, 32'h0, 32'hFFFFDEAD, 1'b0, "w0_lh_12");
        check("tp_period_w0", acceptCyc - a1, 3);
        resetDuringWait(1);

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) op(s, 1, 32'h100 + 32'(4 * w), 3'd2, $urandom, 0, "rnd_init");
            for (int k = 0; k < 40; k++) begin
                bit [31:0] a;
                a = 32'h100 + $urandom_range(0, 63);
                if ($urandom_range(0, 7) == 0) a = 32'(4 * DEPTH) + $urandom_range(0, 255);
                op(s, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 2), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU's data-memory load/store interface.
- Accepts one load or store request at a time over a valid/ready request channel.
- Inserts a configurable number of wait states, performs the byte, half or word access on an internal word-organised array, then returns data or an error over a valid/ready response channel.
- Replaces the zero-latency data memory when the pipeline moves to a stallable memory port.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = req_addr[31:2]
WAIT_CYCLES, 2, wait states between request acceptance and array access (0 allowed)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_funct3  input  3  RV32I funct3 of the load/store instruction
req_wdata  input  32  store data, right-aligned (rs2)
resp_valid  output  1  response present
resp_ready  input  1  requester takes the response
resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
resp_err  output  1  request was rejected; no array write occurred

Behaviour:
- Reset (async, rst=1): state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Array contents are not reset.
- Reset mid-operation: captured request is discarded. A store not yet at its ACCESS edge is never written.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1; req_ready=0 in all other states.
  - On req_valid&req_ready at edge T: capture write, addr, funct3 and wdata.
  - Go to WAIT with counter=WAIT_CYCLES-1; go directly to ACCESS if WAIT_CYCLES=0.
- WAIT: counter decrements each edge. Go to ACCESS on the edge where counter==0.
- ACCESS (one cycle): validate, perform the access, register resp_rdata/resp_err, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_valid&resp_ready.
  - On that handshake edge: go to IDLE, clear resp_valid, resp_rdata and resp_err to 0.
  - resp_valid is first high in the cycle after edge T+WAIT_CYCLES+1.
  - A new request can be accepted at the earliest one cycle after the response handshake (no back-to-back overlap).
- Latency: with resp_ready tied 1, request-to-response is WAIT_CYCLES+2 edges, and one transaction completes every WAIT_CYCLES+3 cycles.
- Validation (any failure sets resp_err=1, rdata=0, no write):
  - Load funct3 must be 0 (lb), 1 (lh), 2 (lw), 4 (lbu) or 5 (lhu). Store funct3 must be 0 (sb), 1 (sh) or 2 (sw).
  - Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
  - Range: addr[31:2] < DEPTH_WORDS.
- Stores: byte-lane write into word addr[31:2].
  - sb: lane addr[1:0] gets wdata[7:0].
  - sh: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - sw: full word.
  - Untouched lanes are preserved. resp_rdata=0, resp_err=0.
- Loads:
  - lb/lbu: select byte lane addr[1:0].
  - lh/lhu: select halfword addr[1].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw returns the word unchanged.
- resp_ready high outside RESP is ignored. req_valid while busy is not accepted; the requester holds its request until req_ready.

Test Plan:
- Reset then sw addr 0x10 wdata 0xDEADBEEF, then lw 0x10 (WAIT_CYCLES=2, resp_ready=1): store response err=0, rdata=0; load rdata=0xDEADBEEF; resp_valid rises 4 edges after acceptance.
- Byte lanes: with word 0x10=0xDEADBEEF, sb 0x13 wdata 0x00000080, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
- Halfword: sh 0x22 wdata 0x12348001, then lh 0x22 -> 0xFFFF8001; lhu 0x22 -> 0x00008001; lw 0x20 -> 0x8001xxxx with low half unchanged.
- Errors: lw 0x11, sh 0x21, lw addr 4*DEPTH_WORDS, and a store with funct3=4 -> each resp_err=1, rdata=0; a following lw of the targeted words shows prior contents.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and data stay stable, req_ready stays 0; raise resp_ready -> one handshake, then req_ready=1 the next cycle.
- Async reset while in WAIT with a pending sw to 0x30 (old value 0x11111111) -> outputs 0 immediately, state IDLE; a subsequent lw 0x30 returns 0x11111111. Repeat with WAIT_CYCLES=0: response after 2 edges.
